// File: rtl/seven_seg_capture.sv
// Recovers hex digits from a multiplexed, active-low 7-segment display bus.
// A stability filter rejects anode-switching ghosts. Each decode is classified as a digit, a blank or an illegal pattern.
module seven_seg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int IDX_W         = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   anode,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic                    pattern_err,
  output logic [IDX_W-1:0]        event_digit
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    update_q, update_d;
  logic                    perr_q, perr_d;
  logic [IDX_W-1:0]        evt_q, evt_d;

  logic                    changed;
  logic                    fire;
  logic                    one_low;
  logic [IDX_W-1:0]        idx;
  logic [4:0]              dec;

  // Returns {hit, value}; exact inverse of the segment encoder table.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h40:   decode_seg = 5'h10;
      7'h79:   decode_seg = 5'h11;
      7'h24:   decode_seg = 5'h12;
      7'h30:   decode_seg = 5'h13;
      7'h19:   decode_seg = 5'h14;
      7'h12:   decode_seg = 5'h15;
      7'h02:   decode_seg = 5'h16;
      7'h78:   decode_seg = 5'h17;
      7'h00:   decode_seg = 5'h18;
      7'h18:   decode_seg = 5'h19;
      7'h08:   decode_seg = 5'h1A;
      7'h03:   decode_seg = 5'h1B;
      7'h27:   decode_seg = 5'h1C;
      7'h21:   decode_seg = 5'h1D;
      7'h06:   decode_seg = 5'h1E;
      7'h0E:   decode_seg = 5'h1F;
      default: decode_seg = 5'h00;
    endcase
  endfunction

  assign changed = ({anode, seg} != {an_q, seg_q});
  // Fires once, on the edge where the counter reaches STABLE_CYCLES-1.
  assign fire    = !changed && (cnt_q == CW'(STABLE_CYCLES - 2));
  assign one_low = $onehot(~an_q);
  assign dec     = decode_seg(seg_q);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) idx = IDX_W'(i);
    end
  end

  always_comb begin
    an_d     = anode;
    seg_d    = seg;
    cnt_d    = cnt_q;
    if (changed) cnt_d = '0;
    else if (cnt_q != CW'(STABLE_CYCLES)) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    evt_d    = evt_q;
    update_d = 1'b0;
    perr_d   = 1'b0;
    if (fire && one_low) begin
      evt_d = idx;
      valid_d[idx] = 1'b0;
      if (dec[4]) begin
        digits_d[4*idx +: 4] = dec[3:0];
        valid_d[idx]         = 1'b1;
        update_d             = 1'b1;
      end else if (seg_q != 7'h7F) begin
        perr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q     <= '1;
      seg_q    <= 7'h7F;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      update_q <= 1'b0;
      perr_q   <= 1'b0;
      evt_q    <= '0;
    end else begin
      an_q     <= an_d;
      seg_q    <= seg_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      perr_q   <= perr_d;
      evt_q    <= evt_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign update      = update_q;
  assign pattern_err = perr_q;
  assign event_digit = evt_q;

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Reverse direction of the hex-to-segment encoder: watches a multiplexed, active-low 7-segment display bus (segment lines plus digit anodes) and recovers the hex value shown on each digit.
- Used to read back and check display output in-system and on the bench, and to feed displayed values to debug logic.
- A per-sample stability filter rejects ghosting during anode switching; each decode is classified as digit, blank or illegal pattern.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines); >= 1.
- STABLE_CYCLES, 4, consecutive identical samples required before a decode; >= 2.
- IDX_W, 2, width of the digit index; must be >= clog2(NUM_DIGITS), with a minimum of 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- anode  input  NUM_DIGITS  digit select, active-low; bit i low means digit i is driven.
- seg  input  7  segment lines, active-low; bit0=a, bit1=b, ..., bit6=g.
- digits  output  4*NUM_DIGITS  captured hex values; digit i is in bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i high when digit i currently holds a legally decoded value.
- update  output  1  one-cycle pulse when a legal digit is written.
- pattern_err  output  1  one-cycle pulse when an illegal segment pattern is decoded.
- event_digit  output  IDX_W  index of the digit that caused the last update, pattern_err or blank.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-filter):
  - digits=0, digit_valid=0, update=0, pattern_err=0, event_digit=0.
  - Filter counter=0.
  - Sample register={anode all 1, seg=7'h7F}.
- Input sampling: {anode, seg} is registered every cycle. The filter compares each new sample with the held sample.
- Filter:
  - Sample differs from the held sample: counter=0 and the held sample is replaced.
  - Sample is identical: counter increments and saturates at STABLE_CYCLES.
  - Decode fires once, on the edge where the counter reaches STABLE_CYCLES-1. No further decode occurs until the sample changes.
- Qualifying: a decode acts only if anode is one-hot-low (exactly one bit 0).
  - All anodes high, or more than one low: no decode, no outputs change.
  - Selected digit index i is taken from the low anode bit.
- Decode table (seg value -> hex); this is the exact inverse of the team's encoder:
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 18->9, 08->A, 03->b, 27->c, 21->d, 06->E, 0E->F
- Decode outcomes:
  - Table hit: digits[i]=value, digit_valid[i]=1, update=1 for one cycle, event_digit=i.
  - seg=7F (blank): digit_valid[i]=0, digits[i] held, event_digit=i, no pulse.
  - Any other pattern: digit_valid[i]=0, digits[i] held, pattern_err=1 for one cycle, event_digit=i.
- Latency: input stable before edge E0 and held. The sample is registered at E0 and the decode result is registered at edge E0+STABLE_CYCLES-1. The pulse is high for the following cycle. With default parameters, the pulse appears 4 edges after the input settles.
- Simultaneous events: at most one decode per cycle, so update and pattern_err are never high together. A change in the same cycle a decode would fire aborts that decode.
- Re-display of an unchanged value after the anode has moved away re-qualifies and pulses update again.
- Counter width: clog2(STABLE_CYCLES+1). Saturation prevents wrap-around for inputs held indefinitely.

Test Plan:
- Reset, then anode=1110, seg=7'h30 held 10 cycles -> one update pulse 4 edges after settling; digits[3:0]=3, digit_valid=0001, event_digit=0; no further pulses.
- Scan digits 0..3 with seg=19,08,00,0E, each held 6 cycles -> digits=16'hF8A4, digit_valid=1111, exactly 4 update pulses with event_digit 0,1,2,3.
- Ghosting: anode=1101 with seg changing every 2 cycles for 12 cycles, then held at 21 -> no pulse during toggling; a single update with digits[7:4]=D.
- Illegal pattern: digit 2 already holds 5 (valid), then anode=1011, seg=7'h7E held -> pattern_err one cycle, event_digit=2, digit_valid[2]=0, digits[11:8] stays 5. Next, seg=7F -> no pulse, valid stays 0.
- Anode=1100 or 1111 with seg=40 held 10 cycles -> no update, no pattern_err, outputs unchanged.
- Assert rst for 1 cycle mid-filter (counter=2) after digits are loaded -> all outputs 0 asynchronously. After release with the same input held, a fresh full 4-edge filter runs before update.
